// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter in front of a single-port data memory
//
// Purpose: accepts load/store requests from m0 and m1, grants one at a time
// (round-robin on ties), performs a single memory access cycle and returns a
// one-cycle completion pulse with zero-extended load data or an error flag.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   mN_req/we/size/addr/wdata  requester N command (held until mN_gnt)
//   mN_gnt                     combinational accept, IDLE only
//   mN_rvalid/rdata/err        completion pulse, load data, illegal-size flag
//   mem_en/we/be/addr/wdata    memory strobe and command, live only in ACCESS
//   mem_rdata                  memory read data, valid the cycle after a read strobe
module dmem_arbiter #(
  parameter int   ADDR_W   = 8,
  parameter logic RST_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                last_grant;
  logic                owner;
  logic                cap_we;
  logic [1:0]          cap_size;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         cap_wdata;
  logic [31:0]         rdata0_q;
  logic [31:0]         rdata1_q;
  logic                grant0;
  logic                grant1;
  logic                legal;
  logic                in_access;
  logic                in_resp;
  logic [3:0]          be;
  logic [31:0]         resp_data;

  // Grant decision and next state. Grants are suppressed while reset is low
  // so nothing is accepted in a reset cycle.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (reset) begin
          if (m0_req && m1_req) begin
            // tie: the requester that did not win last time goes first
            grant0 = last_grant;
            grant1 = ~last_grant;
          end else begin
            grant0 = m0_req;
            grant1 = m1_req;
          end
        end
        if (grant0 || grant1) state_next = ACCESS;
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= RST_LAST;
      owner      <= 1'b0;
      cap_we     <= 1'b0;
      cap_size   <= 2'b00;
      cap_addr   <= '0;
      cap_wdata  <= 32'h0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      state <= state_next;
      if (grant0 || grant1) begin
        last_grant <= grant1;
        owner      <= grant1;
        cap_we     <= grant1 ? m1_we    : m0_we;
        cap_size   <= grant1 ? m1_size  : m0_size;
        cap_addr   <= grant1 ? m1_addr  : m0_addr;
        cap_wdata  <= grant1 ? m1_wdata : m0_wdata;
      end
      // keep the last returned value so rdata holds between pulses
      if (state == RESP) begin
        if (owner) rdata1_q <= resp_data;
        else       rdata0_q <= resp_data;
      end
    end
  end

  assign legal     = (cap_size != 2'b11);
  // reset gates the live phases so an in-flight access produces no strobe or pulse
  assign in_access = reset && (state == ACCESS) && legal;
  assign in_resp   = reset && (state == RESP);

  // stores drive only the low lanes; loads always fetch the full word
  always_comb begin
    be = 4'b1111;
    if (cap_we) begin
      case (cap_size)
        2'b00:   be = 4'b0001;
        2'b01:   be = 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    resp_data = 32'h0;
    if (legal && !cap_we) begin
      case (cap_size)
        2'b00:   resp_data = {24'h0, mem_rdata[7:0]};
        2'b01:   resp_data = {16'h0, mem_rdata[15:0]};
        default: resp_data = mem_rdata;
      endcase
    end
  end

  assign mem_en    = in_access;
  assign mem_we    = in_access & cap_we;
  assign mem_be    = in_access ? be        : 4'h0;
  assign mem_addr  = in_access ? cap_addr  : '0;
  assign mem_wdata = in_access ? cap_wdata : 32'h0;

  assign m0_gnt    = grant0;
  assign m1_gnt    = grant1;
  assign m0_rvalid = in_resp & ~owner;
  assign m1_rvalid = in_resp & owner;
  assign m0_err    = in_resp & ~owner & ~legal;
  assign m1_err    = in_resp & owner & ~legal;
  // load data is only available from memory in RESP, so the pulse cycle
  // forwards it directly and the register takes over afterwards
  assign m0_rdata  = !reset ? 32'h0 : ((in_resp && !owner) ? resp_data : rdata0_q);
  assign m1_rdata  = !reset ? 32'h0 : ((in_resp && owner)  ? resp_data : rdata1_q);

endmodule
